// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store sequencer driving the DataMemory pins.
// Define MEMACC_ALIGN_CHECK_EN to fault odd-address halfword accesses.
module mem_access_unit #(
    parameter int ADDR_LIMIT = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_rd,
    output logic        mem_wn,
    output logic [15:0] mem_address,
    output logic        mem_mode,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t      r_state, w_next;
    logic        r_byte, r_signed, r_fault;
    logic [15:0] r_addr, r_wdata, r_rdata;
    logic        w_in_range, w_misaligned, w_fault, w_accept;

    // 17-bit compare so addr+1 cannot wrap back into range
    assign w_in_range = req_byte ? ({1'b0, req_addr} < 17'(ADDR_LIMIT))
                                 : ({1'b0, req_addr} + 17'd1 < 17'(ADDR_LIMIT));
`ifdef MEMACC_ALIGN_CHECK_EN
    assign w_misaligned = ~req_byte & req_addr[0];
`else
    assign w_misaligned = 1'b0;
`endif
    assign w_fault  = ~w_in_range | w_misaligned;
    assign w_accept = (r_state == IDLE) & req_valid;

    always_ff @(posedge clk) begin
        r_state <= !rst_n ? IDLE : w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE)  ? (req_valid ? (w_fault ? RESP : (req_we ? WRITE : READ)) : IDLE) :
                 (r_state == RESP)  ? (resp_ready ? IDLE : RESP) : RESP;
    end

    always_comb begin
        req_ready  = r_state == IDLE;
        resp_valid = r_state == RESP;
        mem_rd     = r_state == READ;
        mem_wn     = (r_state == WRITE) & rst_n;
    end

    // Faulting requests leave the memory-side registers untouched so the pins never move
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byte   <= 1'b0;
            r_signed <= 1'b0;
            r_fault  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else if (w_accept) begin
            r_signed <= req_signed;
            r_fault  <= w_fault;
            r_rdata  <= '0;
            if (!w_fault) begin
                r_byte  <= req_byte;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end else if (r_state == READ) begin
            r_rdata <= r_byte ? {{8{r_signed & mem_read_data[15]}}, mem_read_data[15:8]} : mem_read_data;
        end
    end

    assign resp_rdata     = r_rdata;
    assign resp_fault     = r_fault;
    assign mem_address    = r_addr;
    assign mem_mode       = r_byte;
    assign mem_write_data = r_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives mem_access_unit against a behavioural DataMemory and
// compares every response with an array-based reference model.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready, resp_valid, resp_fault, mem_rd, mem_wn, mem_mode;
    logic [15:0] resp_rdata, mem_address, mem_write_data, mem_read_data, w_a1;
    logic        mem_init = 1'b1;
    logic [7:0]  dmem [0:2047];
    logic [7:0]  ref_mem [0:2047];
    int          checks = 0, failures = 0;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_address(mem_address),
        .mem_mode(mem_mode), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign w_a1 = mem_address + 16'd1;
    assign mem_read_data = {(mem_address < 16'd2048) ? dmem[mem_address[10:0]] : 8'h00,
                            (mem_address < 16'd2047) ? dmem[w_a1[10:0]] : 8'h00};

    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) dmem[i] <= (i < 16) ? 8'(i + 1) : 8'h00;
        end else if (mem_wn) begin
            if (mem_mode) begin
                if (mem_address < 16'd2048) dmem[mem_address[10:0]] <= mem_write_data[7:0];
            end else if (mem_address < 16'd2047) begin
                dmem[mem_address[10:0]] <= mem_write_data[15:8];
                dmem[w_a1[10:0]]        <= mem_write_data[7:0];
            end
        end
    end

    function automatic bit ref_fault(input bit bt, input logic [15:0] a);
        int ai = int'(a);
        bit f = bt ? (ai >= 2048) : (ai + 1 >= 2048);
`ifdef MEMACC_ALIGN_CHECK_EN
        if (!bt && (ai % 2 == 1)) f = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic [15:0] ref_load(input bit bt, input bit sg, input logic [15:0] a);
        int v;
        if (bt) begin
            v = int'(ref_mem[a[10:0]]);
            if (sg && v >= 128) v = v - 256;
            return 16'(v);
        end
        return {ref_mem[a[10:0]], ref_mem[a[10:0] + 11'd1]};
    endfunction

    task automatic ref_store(input bit bt, input logic [15:0] a, input logic [15:0] wd);
        if (bt) ref_mem[a[10:0]] = wd[7:0];
        else begin
            ref_mem[a[10:0]]         = wd[15:8];
            ref_mem[a[10:0] + 11'd1] = wd[7:0];
        end
    endtask

    // Drives one request from an IDLE cycle and completes its response handshake.
    task automatic issue(input bit we, input bit bt, input bit sg, input logic [15:0] a,
                         input logic [15:0] wd, output logic [15:0] rdata, output logic fault,
                         output int lat, output bit saw_rd, output bit saw_wn);
        req_valid = 1'b1; req_we = we; req_byte = bt; req_signed = sg;
        req_addr = a; req_wdata = wd; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; saw_rd = 1'b0; saw_wn = 1'b0;
        while (!resp_valid && lat < 10) begin
            saw_rd |= mem_rd;
            saw_wn |= mem_wn;
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        fault = resp_fault;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got %b expected 0", resp_valid); end
        checks++; if ({resp_fault, resp_rdata} !== 17'h0) begin failures++; $display("FAIL reset_resp got %h expected 0", {resp_fault, resp_rdata}); end
        checks++; if ({mem_rd, mem_wn, mem_mode} !== 3'b000) begin failures++; $display("FAIL reset_mem_ctl got %b expected 000", {mem_rd, mem_wn, mem_mode}); end
        checks++; if ({mem_address, mem_write_data} !== 32'h0) begin failures++; $display("FAIL reset_mem_bus got %h expected 0", {mem_address, mem_write_data}); end
        for (int i = 0; i < 2048; i++) ref_mem[i] = (i < 16) ? 8'(i + 1) : 8'h00;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_hw_load();
        logic [15:0] rd; logic f; int lat; bit sr, sw;
        issue(1'b0, 1'b0, 1'b0, 16'd4, 16'h0, rd, f, lat, sr, sw);
        checks++; if (rd !== 16'h0506) begin failures++; $display("FAIL hw_load_rdata got %h expected 0506", rd); end
        checks++; if (f !== 1'b0) begin failures++; $display("FAIL hw_load_fault got %b expected 0", f); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL hw_load_latency got %0d expected 1", lat); end
        checks++; if ({sr, sw} !== 2'b10) begin failures++; $display("FAIL hw_load_pins got %b expected 10", {sr, sw}); end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_r = ref_load(1'b0, 1'b0, 16'd0);
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 16'd0; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({resp_valid, req_ready, resp_rdata} !== {2'b10, exp_r}) begin
                failures++;
                $display("FAIL hold_cycle%0d got valid=%b ready=%b rdata=%h expected 1 0 %h", c, resp_valid, req_ready, resp_rdata, exp_r);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL hold_release got %b expected 01", {resp_valid, req_ready}); end
    endtask

    task automatic test_byte_access();
        logic [15:0] rd; logic f; int lat; bit sr, sw;
        issue(1'b1, 1'b1, 1'b0, 16'd2, 16'h1F80, rd, f, lat, sr, sw);
        ref_store(1'b1, 16'd2, 16'h1F80);
        checks++; if ({f, rd, sr, sw} !== {1'b0, 16'h0, 2'b01}) begin failures++; $display("FAIL byte_store got f=%b rd=%h rd_wn=%b%b expected 0 0000 01", f, rd, sr, sw); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL byte_store_latency got %0d expected 1", lat); end
        issue(1'b0, 1'b1, 1'b1, 16'd2, 16'h0, rd, f, lat, sr, sw);
        checks++; if (rd !== 16'hFF80) begin failures++; $display("FAIL byte_load_signed got %h expected FF80", rd); end
        issue(1'b0, 1'b1, 1'b0, 16'd2, 16'h0, rd, f, lat, sr, sw);
        checks++; if (rd !== 16'h0080) begin failures++; $display("FAIL byte_load_unsigned got %h expected 0080", rd); end
        checks++; if (dmem[3] !== 8'h04) begin failures++; $display("FAIL byte_store_neighbour got %h expected 04", dmem[3]); end
    endtask

    task automatic test_boundary();
        logic [15:0] rd; logic f; int lat; bit sr, sw;
        issue(1'b1, 1'b0, 1'b0, 16'd2046, 16'hBEEF, rd, f, lat, sr, sw);
        ref_store(1'b0, 16'd2046, 16'hBEEF);
        issue(1'b0, 1'b0, 1'b0, 16'd2046, 16'h0, rd, f, lat, sr, sw);
        checks++; if ({f, rd} !== {1'b0, 16'hBEEF}) begin failures++; $display("FAIL hw_2046 got f=%b rd=%h expected 0 BEEF", f, rd); end
        issue(1'b0, 1'b0, 1'b0, 16'd2047, 16'h0, rd, f, lat, sr, sw);
        checks++; if ({f, rd} !== {1'b1, 16'h0}) begin failures++; $display("FAIL hw_2047 got f=%b rd=%h expected 1 0000", f, rd); end
        checks++; if ({sr, lat} !== {1'b0, 0}) begin failures++; $display("FAIL hw_2047_pins got rd=%b lat=%0d expected 0 0", sr, lat); end
        issue(1'b0, 1'b1, 1'b0, 16'd2047, 16'h0, rd, f, lat, sr, sw);
        checks++; if ({f, rd} !== {1'b0, 16'hEF}) begin failures++; $display("FAIL byte_2047 got f=%b rd=%h expected 0 00EF", f, rd); end
        issue(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0, rd, f, lat, sr, sw);
        checks++; if (f !== 1'b1) begin failures++; $display("FAIL byte_ffff got %b expected 1", f); end
        issue(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h1234, rd, f, lat, sr, sw);
        checks++; if ({f, sw} !== 2'b10) begin failures++; $display("FAIL hw_store_ffff got f=%b wn=%b expected 1 0", f, sw); end
    endtask

    task automatic test_align();
        logic [15:0] rd; logic f; int lat; bit sr, sw;
        issue(1'b0, 1'b0, 1'b0, 16'd5, 16'h0, rd, f, lat, sr, sw);
`ifdef MEMACC_ALIGN_CHECK_EN
        checks++; if ({f, rd, sr} !== {1'b1, 16'h0, 1'b0}) begin failures++; $display("FAIL odd_hw got f=%b rd=%h rdpin=%b expected 1 0000 0", f, rd, sr); end
`else
        checks++; if ({f, rd} !== {1'b0, 16'h0607}) begin failures++; $display("FAIL odd_hw got f=%b rd=%h expected 0 0607", f, rd); end
`endif
    endtask

    task automatic test_reset_mid_write();
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 16'd8; req_wdata = 16'hAAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_wn !== 1'b0) begin failures++; $display("FAIL midwrite_wn_gated got %b expected 0", mem_wn); end
        @(posedge clk); #1;
        checks++; if ({dmem[8], dmem[9]} !== 16'h090A) begin failures++; $display("FAIL midwrite_mem got %h expected 090A", {dmem[8], dmem[9]}); end
        checks++;
        if ({req_ready, resp_valid, resp_fault, resp_rdata, mem_rd, mem_wn, mem_mode, mem_address, mem_write_data} !== {2'b10, 17'h0, 3'b000, 32'h0}) begin
            failures++;
            $display("FAIL midwrite_outputs got rdy=%b v=%b f=%b rd=%h ctl=%b a=%h wd=%h expected reset values",
                     req_ready, resp_valid, resp_fault, resp_rdata, {mem_rd, mem_wn, mem_mode}, mem_address, mem_write_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int k;
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 16'd4; resp_ready = 1'b1;
        for (k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (req_ready) break;
        end
        checks++; if (k !== 3) begin failures++; $display("FAIL b2b_access_period got %0d expected 3", k); end
        req_addr = 16'hFFFF;
        for (k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (req_ready) break;
        end
        checks++; if (k !== 2) begin failures++; $display("FAIL b2b_fault_period got %0d expected 2", k); end
        req_valid = 1'b0; resp_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] rd, a, wd, exp_r, prev_a; logic f; int lat, bad; bit sr, sw, we, bt, sg, exp_f;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1)); bt = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            case ($urandom_range(0, 3))
                0: a = 16'($urandom_range(0, 31));
                1: a = 16'($urandom_range(2040, 2047));
                2: a = 16'($urandom_range(2045, 2052));
                default: a = 16'($urandom);
            endcase
            exp_f = ref_fault(bt, a);
            exp_r = (exp_f || we) ? 16'h0 : ref_load(bt, sg, a);
            prev_a = mem_address;
            issue(we, bt, sg, a, wd, rd, f, lat, sr, sw);
            checks++;
            if ({f, rd} !== {exp_f, exp_r}) begin
                failures++;
                $display("FAIL rand%0d_resp we=%b byte=%b sgn=%b addr=%h got f=%b rd=%h expected %b %h", n, we, bt, sg, a, f, rd, exp_f, exp_r);
            end
            checks++;
            if ({lat, sr, sw} !== {exp_f ? 0 : 1, !exp_f && !we, !exp_f && we}) begin
                failures++;
                $display("FAIL rand%0d_timing got lat=%0d rd=%b wn=%b expected %0d %b %b", n, lat, sr, sw, exp_f ? 0 : 1, !exp_f && !we, !exp_f && we);
            end
            if (exp_f) begin
                checks++;
                if (mem_address !== prev_a) begin failures++; $display("FAIL rand%0d_fault_addr_moved got %h expected %h", n, mem_address, prev_a); end
            end
            if (!exp_f && we) ref_store(bt, a, wd);
        end
        bad = 0;
        for (int i = 0; i < 2048; i++) if (dmem[i] !== ref_mem[i]) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL rand_memory_image got %0d differing bytes expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_hw_load();
        test_backpressure();
        test_byte_access();
        test_boundary();
        test_align();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
